// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   uart_tx_state_t        : transmitter FSM state encoding
//   UART_CLKS_PER_BIT_DEF  : default clocks per serial bit (50 MHz / 115200)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/uart_tx_if.sv
// Bus-side transmit handshake between the core control logic and uart_tx.
//   tx_start : request, sampled by the transmitter only while idle
//   tx_data  : word to send, captured on the edge that accepts tx_start
//   tx_busy  : frame in progress
//   tx_done  : one-cycle pulse when a frame's stop bit completes
// Handshake: the master raises tx_start (pulse or level) with tx_data valid;
// the word is taken at the first rising edge where the transmitter is idle.
// Requests while tx_busy is high are dropped, nothing is queued.
// Modports: master = core side, slave = transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Modulo-CLKS_PER_BIT baud counter, shared by the UART transmitter and receiver.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   clear    : synchronous clear, holds the count at 0
//   bit_tick : high during the last clock of each bit period
// bit_tick decodes the registered count only, so it carries no path from clear.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count;

    assign bit_tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serializes a captured word LSB-first as
// start(0), DATA_WIDTH data bits, [even parity], stop(1).
// Optional feature macro: UART_TX_PARITY_EN adds the even-parity bit.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset; aborts any frame in flight
//   bus   : uart_tx_if.slave (tx_start, tx_data, tx_busy, tx_done)
//   tx    : serial line, idles high
//   state : current FSM state (uart_tx_state_t encoding) for observation
// All outputs are registered; tx is loaded with the level of the bit the
// FSM is entering, so it changes on the same edge as the state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif
    localparam logic [2:0] S_STOP   = STOP;

    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    logic [2:0]            state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  busy_q;
    logic                  done_q;
    logic                  bit_tick;
    logic                  last_bit;
`ifdef UART_TX_PARITY_EN
    // Parity is taken from the word at capture time, since the shift
    // register no longer holds it once data bits have gone out.
    logic                  parity_q;
`endif

    assign state       = state_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

    assign shift_next = shift_q >> 1;
    assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

    // Counter is held at 0 while idle, so every frame starts on a fresh bit period.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == S_IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.tx_start) begin
                        shift_q  <= bus.tx_data;
                        bit_cnt  <= '0;
                        state_q  <= S_START;
                        busy_q   <= 1'b1;
                        tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^bus.tx_data;
`endif
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        state_q <= S_DATA;
                        tx      <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_next;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx      <= parity_q;
`else
                            state_q <= S_STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            tx <= shift_next[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_tick) begin
                        state_q <= S_STOP;
                        tx      <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_tick) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLKS_PER_BIT=4, DATA_WIDTH=8. Expected line
// activity comes from a frame model that lists the frame's bits and
// stretches each to CLKS_PER_BIT cycles. Observed vector per cycle is
// {tx, tx_busy, tx_done}. Define UART_TX_PARITY_EN for the parity build.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic       clk;
    logic       rst;
    logic       tx;
    logic [2:0] state;

    int vectors;
    int miscompares;

    logic [2:0] exp_q[$];

    uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .tx    (tx),
        .state (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] obs();
        return {tx, bus.tx_busy, bus.tx_done};
    endfunction

    // Reference model: the per-cycle expectation for one frame starting
    // the cycle after acceptance, followed by the single done cycle.
    task automatic build_exp(input logic [DW-1:0] d);
        logic bits[$];
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < CPB; k++) exp_q.push_back({bits[i], 1'b1, 1'b0});
        exp_q.push_back(3'b101);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (obs() !== 3'b100) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", c, obs(), 3'b100);
            end
        end
        vectors++;
        if (state !== 3'(IDLE)) begin
            miscompares++;
            $display("FAIL reset_state got=%0d exp=%0d", state, 3'(IDLE));
        end
        bus.tx_start = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_frames();
        logic [DW-1:0] d;
        int gap;
        for (int n = 0; n < 8; n++) begin
            d   = (n == 0) ? 8'hA5 : (n == 1) ? 8'h07 : 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                vectors++;
                if (obs() !== 3'b100) begin
                    miscompares++;
                    $display("FAIL frame_idle n=%0d got=%b exp=%b", n, obs(), 3'b100);
                end
                tick();
            end
            build_exp(d);
            bus.tx_start = 1'b1;
            bus.tx_data  = d;
            tick();
            bus.tx_start = 1'b0;
            bus.tx_data  = 8'($urandom_range(0, 255));
            foreach (exp_q[c]) begin
                vectors++;
                if (obs() !== exp_q[c]) begin
                    miscompares++;
                    $display("FAIL frame d=%h cyc=%0d got=%b exp=%b", d, c + 1, obs(), exp_q[c]);
                end
                tick();
            end
            vectors++;
            if (obs() !== 3'b100) begin
                miscompares++;
                $display("FAIL frame_after d=%h got=%b exp=%b", d, obs(), 3'b100);
            end
        end
    endtask

    task automatic test_busy_reject();
        int inj;
        inj = CPB + 3 * CPB + 1;
        build_exp(8'hA5);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hA5;
        tick();
        bus.tx_start = 1'b0;
        foreach (exp_q[c]) begin
            vectors++;
            if (obs() !== exp_q[c]) begin
                miscompares++;
                $display("FAIL busy_reject cyc=%0d got=%b exp=%b", c + 1, obs(), exp_q[c]);
            end
            bus.tx_start = (c == inj);
            bus.tx_data  = (c == inj) ? 8'hFF : 8'hA5;
            tick();
        end
        for (int c = 0; c < exp_q.size() + 4; c++) begin
            vectors++;
            if (obs() !== 3'b100) begin
                miscompares++;
                $display("FAIL busy_reject_idle cyc=%0d got=%b exp=%b", c, obs(), 3'b100);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d2;
        logic [2:0]    exp2[$];
        d2 = 8'($urandom_range(0, 255));
        build_exp(d2);
        exp2 = exp_q;
        build_exp(8'h3C);
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h3C;
        tick();
        bus.tx_start = 1'b0;
        foreach (exp_q[c]) begin
            vectors++;
            if (obs() !== exp_q[c]) begin
                miscompares++;
                $display("FAIL b2b_first cyc=%0d got=%b exp=%b", c + 1, obs(), exp_q[c]);
            end
            // Raise the next request during the last stop cycle and hold it
            // through the done cycle.
            if (c == exp_q.size() - 2) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = d2;
            end
            tick();
        end
        bus.tx_start = 1'b0;
        foreach (exp2[c]) begin
            vectors++;
            if (obs() !== exp2[c]) begin
                miscompares++;
                $display("FAIL b2b_second d=%h cyc=%0d got=%b exp=%b", d2, c + 1, obs(), exp2[c]);
            end
            tick();
        end
        vectors++;
        if (obs() !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_after got=%b exp=%b", obs(), 3'b100);
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] d;
        int stop_at;
        d = 8'($urandom_range(0, 255));
        build_exp(d);
        stop_at = CPB + 5 * CPB + 2;
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        tick();
        bus.tx_start = 1'b0;
        for (int c = 0; c < stop_at; c++) begin
            vectors++;
            if (obs() !== exp_q[c]) begin
                miscompares++;
                $display("FAIL mid_reset_pre cyc=%0d got=%b exp=%b", c + 1, obs(), exp_q[c]);
            end
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (obs() !== 3'b100) begin
            miscompares++;
            $display("FAIL mid_reset_async got=%b exp=%b", obs(), 3'b100);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < exp_q.size() + 4; c++) begin
            vectors++;
            if (obs() !== 3'b100) begin
                miscompares++;
                $display("FAIL mid_reset_after cyc=%0d got=%b exp=%b", c, obs(), 3'b100);
            end
            tick();
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        test_reset();
        test_frames();
        test_busy_reject();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter peripheral for the RISC-V core. It reads a data word written by the core into its memory-mapped transmit register, then serializes it LSB-first onto an asynchronous serial line. The frame is one start bit, DATA_WIDTH data bits, an optional even-parity bit and one stop bit. It is the transmit end of the serial link whose receiver the core reads from, and it reports completion back to the bus-side control logic.

## Interface
- DATA_WIDTH, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be >= 2.

- clk  input  1  system clock, rising edge active.
- rst  input  1  asynchronous, active-low reset.
- tx_start  input  1  request; sampled only in IDLE; one-cycle pulse or level.
- tx_data  input  DATA_WIDTH  word to send; captured on the edge that accepts tx_start.
- tx  output  1  serial line; idle/mark = 1.
- tx_busy  output  1  high while a frame is in progress (state != IDLE).
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- IDLE: tx=1. If tx_start=1 at a rising edge: latch tx_data into the shift register, clear the bit and baud counters, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift_reg[0]. After every CLKS_PER_BIT cycles, shift right by 1 and increment the bit counter. After DATA_WIDTH bits, go to PARITY, or to STOP if the macro is absent.
- PARITY: tx = XOR of the captured word (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE and set tx_done=1 for exactly one cycle.
- Baud counter width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit counter width: $clog2(DATA_WIDTH)+1.
- tx_start while busy: ignored, with no queuing. tx_data changes after capture have no effect.
- Reset: tx=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously: tx returns to 1 and no tx_done is issued.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- If tx_start is accepted at edge N:
  - tx falls and tx_busy rises after edge N.
  - The start bit occupies cycles N..N+CLKS_PER_BIT-1.
- Frame length is (DATA_WIDTH+2)*CLKS_PER_BIT cycles, or (DATA_WIDTH+3)*CLKS_PER_BIT with parity.
- tx_done and tx_busy=0 appear in the same cycle, the first IDLE cycle after the stop bit.
- Back-to-back frames: tx_start held high or pulsed during the tx_done cycle is accepted at the next edge. The minimum inter-frame gap is therefore one idle-high cycle after the stop bit.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is compiled in, and one even-parity bit is sent between the last data bit and the stop bit.
  - Undefined: the PARITY state and parity logic are absent, giving an 8N1-style frame.

## Structure
- Package uart_pkg:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - localparam UART_CLKS_PER_BIT_DEF = 434.
  - Shared with the receiver.
- Sub-module uart_baud_cnt:
  - Parameterized modulo-CLKS_PER_BIT counter with clear input and one-cycle bit_tick output.
  - Same clk and asynchronous active-low rst.
  - Reused by the receiver.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=8.
- Reset: hold rst=0 with tx_start=1 -> tx=1, tx_busy=0, tx_done=0 throughout.
- Send 0xA5 (macro undefined) -> tx holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles total). tx_done pulses once, in cycle 41 after acceptance; tx_busy is high for cycles 1..40.
- Busy rejection: pulse tx_start with 0xFF during bit 3 of a 0xA5 frame -> the 0xA5 frame is unchanged, no second frame follows, tx_done pulses once.
- Back-to-back: 0x3C followed by tx_start held high through the tx_done cycle -> exactly one idle-high cycle, then start bit, then 0,0,1,1,1,1,0,0, then stop.
- Mid-frame reset: assert rst=0 during bit 5 -> tx=1 and tx_busy=0 asynchronously. After release, the line stays idle and no tx_done is issued.
- UART_TX_PARITY_EN defined:
  - 0xA5 -> parity bit 0 occupies cycles 37..40, stop bit occupies 41..44.
  - 0x07 -> parity bit 1.
  - Frame length is 44 cycles.
